led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_seq_pkg.sv | 31 +++
 rtl/led_sequencer_tick_gen.sv | 26 ++
 rtl/led_sequencer.sv | 154 +++++++++++++++
 tb/tb_led_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED sequencer: the 2-bit display mode
// enumeration, the LED constants used on pattern reinitialisation, and the
// mode rotation helper.
// ---------------------------------------------------------------------------
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_BLINK   = 2'd3
   } mode_e;

   localparam logic [7:0] SCAN_INIT = 8'h01;
   localparam logic [7:0] LEDS_OFF  = 8'h00;

   // COUNT -> SCAN -> BREATHE -> BLINK -> COUNT
   function automatic mode_e next_mode(input mode_e m);
      mode_e r;
      case (m)
         MODE_COUNT:   r = MODE_SCAN;
         MODE_SCAN:    r = MODE_BREATHE;
         MODE_BREATHE: r = MODE_BLINK;
         default:      r = MODE_COUNT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running WIDTH-bit prescaler. tick is high for the one clock in which
// the counter sits at all-ones, i.e. once every 2^WIDTH clocks.
//   clk  : system clock
//   rst  : synchronous active-high reset (counter to 0)
//   tick : one-cycle strobe at counter == all-ones
// ---------------------------------------------------------------------------
module tick_gen #(
   parameter int WIDTH = 18
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt + 1'b1;
   end

   assign tick = &cnt;

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
// Drives an 8-LED bank with one of four patterns (COUNT, SCAN, BREATHE,
// BLINK). Patterns step once per prescaler tick unless held; a rising edge on
// mode_req rotates to the next mode and restarts all pattern state.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   mode_req : level input, each 0->1 transition advances the mode
//   hold     : freezes pattern stepping while high
//   leds     : registered LED drive, bit 7 = leftmost
//   mode     : current mode (0 COUNT, 1 SCAN, 2 BREATHE, 3 BLINK)
//   tick     : prescaler strobe
// ---------------------------------------------------------------------------
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int PRESCALE_W = 18,
   parameter int PWM_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_req,
   input  logic       hold,
   output logic [7:0] leds,
   output logic [1:0] mode,
   output logic       tick
);

   mode_e              mode_q, mode_d;
   logic               req_prev_q;
   logic [7:0]         cnt_q, cnt_d;
   logic [7:0]         pos_q, pos_d;
   logic               sdir_up_q, sdir_up_d;
   logic [PWM_W-1:0]   lvl_q, lvl_d;
   logic               ldir_up_q, ldir_up_d;
   logic               phase_q, phase_d;
   logic [PWM_W-1:0]   pwm_q, pwm_d;
   logic [7:0]         leds_q, leds_d;
   logic               advance;
   logic               step;

   tick_gen #(.WIDTH(PRESCALE_W)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // A mode advance swallows a coincident tick so the new pattern starts
   // from its initial state rather than one step in.
   assign advance = mode_req & ~req_prev_q;
   assign step    = tick & ~hold & ~advance;

   always_comb begin
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      sdir_up_d = sdir_up_q;
      lvl_d     = lvl_q;
      ldir_up_d = ldir_up_q;
      phase_d   = phase_q;
      pwm_d     = pwm_q + 1'b1;
      leds_d    = LEDS_OFF;

      if (advance) begin
         mode_d    = next_mode(mode_q);
         cnt_d     = LEDS_OFF;
         pos_d     = SCAN_INIT;
         sdir_up_d = 1'b1;
         lvl_d     = '0;
         ldir_up_d = 1'b1;
         phase_d   = 1'b0;
      end else if (step) begin
         case (mode_q)
            MODE_COUNT: cnt_d = cnt_q + 8'd1;
            MODE_SCAN: begin
               // Reverse at the ends by jumping to the neighbour so the end
               // positions are never shown twice in a row.
               if (sdir_up_q) begin
                  if (pos_q == 8'h80) begin
                     pos_d     = 8'h40;
                     sdir_up_d = 1'b0;
                  end else begin
                     pos_d = pos_q << 1;
                  end
               end else begin
                  if (pos_q == 8'h01) begin
                     pos_d     = 8'h02;
                     sdir_up_d = 1'b1;
                  end else begin
                     pos_d = pos_q >> 1;
                  end
               end
            end
            MODE_BREATHE: begin
               if (ldir_up_q) begin
                  if (lvl_q == '1) begin
                     lvl_d     = lvl_q - 1'b1;
                     ldir_up_d = 1'b0;
                  end else begin
                     lvl_d = lvl_q + 1'b1;
                  end
               end else begin
                  if (lvl_q == '0) begin
                     lvl_d     = lvl_q + 1'b1;
                     ldir_up_d = 1'b1;
                  end else begin
                     lvl_d = lvl_q - 1'b1;
                  end
               end
            end
            default: phase_d = ~phase_q;
         endcase
      end

      // The LED register is loaded from next-state values so that a step or
      // advance shows on leds right after the edge that causes it.
      case (mode_d)
         MODE_COUNT:   leds_d = cnt_d;
         MODE_SCAN:    leds_d = pos_d;
         MODE_BREATHE: leds_d = {8{pwm_d < lvl_d}};
         default:      leds_d = phase_d ? 8'hFF : LEDS_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= MODE_COUNT;
         req_prev_q <= 1'b1;
         cnt_q      <= LEDS_OFF;
         pos_q      <= SCAN_INIT;
         sdir_up_q  <= 1'b1;
         lvl_q      <= '0;
         ldir_up_q  <= 1'b1;
         phase_q    <= 1'b0;
         pwm_q      <= '0;
         leds_q     <= LEDS_OFF;
      end else begin
         mode_q     <= mode_d;
         req_prev_q <= mode_req;
         cnt_q      <= cnt_d;
         pos_q      <= pos_d;
         sdir_up_q  <= sdir_up_d;
         lvl_q      <= lvl_d;
         ldir_up_q  <= ldir_up_d;
         phase_q    <= phase_d;
         pwm_q      <= pwm_d;
         leds_q     <= leds_d;
      end
   end

   assign leds = leds_q;
   assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
// Directed bench for led_sequencer with PRESCALE_W=2 (tick every 4 clocks)
// and PWM_W=2 (brightness levels 0..3).
// ---------------------------------------------------------------------------
module tb_led_sequencer;

   logic       clk;
   logic       rst;
   logic       mode_req;
   logic       hold;
   logic [7:0] leds;
   logic [1:0] mode;
   logic       tick;

   int n_chk  = 0;
   int n_fail = 0;

   led_sequencer #(.PRESCALE_W(2), .PWM_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .mode_req (mode_req),
      .hold     (hold),
      .leds     (leds),
      .mode     (mode),
      .tick     (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Move forward until tick is high (bounded), leaving the next edge unused.
   task automatic wait_tick();
      int guard;
      guard = 0;
      while (tick !== 1'b1 && guard < 8) begin
         step();
         guard++;
      end
      chk("tick_seen", {7'd0, tick}, 8'h01);
   endtask

   // Let the next pattern step happen and settle after it.
   task automatic next_step();
      wait_tick();
      step();
   endtask

   // Count the fully-on cycles across four consecutive clocks (one PWM
   // period). Any value other than 0x00/0xFF poisons the count.
   task automatic measure(output int on);
      on = 0;
      for (int k = 0; k < 4; k++) begin
         if (leds === 8'hFF)      on++;
         else if (leds !== 8'h00) on += 100;
         if (k < 3) step();
      end
   endtask

   logic [7:0] scan_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
   int         lvl_exp  [7]  = '{1, 2, 3, 2, 1, 0, 1};

   initial begin
      int on;
      rst      = 1'b1;
      mode_req = 1'b0;
      hold     = 1'b0;
      step();
      step();
      chk("rst_mode", {6'd0, mode}, 8'h00);
      chk("rst_leds", leds, 8'h00);
      chk("rst_tick", {7'd0, tick}, 8'h00);

      // COUNT from reset: prescaler 0 after reset, tick on the third clock.
      rst = 1'b0;
      step();
      step();
      chk("tick_low_cnt2", {7'd0, tick}, 8'h00);
      step();
      chk("tick_high_cnt3", {7'd0, tick}, 8'h01);
      chk("count_before_step", leds, 8'h00);
      step();
      chk("count_first", leds, 8'h01);
      chk("tick_low_after", {7'd0, tick}, 8'h00);
      for (int i = 2; i <= 5; i++) begin
         next_step();
         chk("count_seq", leds, 8'(i));
      end

      // Hold freezes the pattern while the prescaler keeps ticking.
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_step();
         chk("hold_leds", leds, 8'h05);
      end
      hold = 1'b0;
      next_step();
      chk("hold_release", leds, 8'h06);

      // Run the counter up to 0xFF and across the wrap.
      for (int i = 7; i <= 255; i++) begin
         next_step();
         chk("count_run", leds, 8'(i));
      end
      next_step();
      chk("count_wrap", leds, 8'h00);

      // Advance to SCAN and walk the bounce sequence.
      mode_req = 1'b1;
      step();
      chk("scan_mode", {6'd0, mode}, 8'h01);
      chk("scan_init", leds, 8'h01);
      mode_req = 1'b0;
      for (int i = 0; i < 15; i++) begin
         next_step();
         chk("scan_seq", leds, scan_exp[i]);
      end

      // Advance coinciding with a tick: no SCAN step, BREATHE at level 0.
      wait_tick();
      mode_req = 1'b1;
      step();
      mode_req = 1'b0;
      chk("breathe_mode", {6'd0, mode}, 8'h02);
      chk("breathe_init", leds, 8'h00);
      measure(on);
      chk("breathe_lvl0", 8'(on), 8'h00);
      for (int i = 0; i < 7; i++) begin
         next_step();
         measure(on);
         chk("breathe_duty", 8'(on), 8'(lvl_exp[i]));
      end

      // BLINK toggles per step starting dark.
      mode_req = 1'b1;
      step();
      mode_req = 1'b0;
      chk("blink_mode", {6'd0, mode}, 8'h03);
      chk("blink_init", leds, 8'h00);
      next_step();
      chk("blink_on", leds, 8'hFF);
      next_step();
      chk("blink_off", leds, 8'h00);

      // mode_req held high for 20 clocks gives exactly one advance.
      mode_req = 1'b1;
      step();
      chk("held_mode", {6'd0, mode}, 8'h00);
      chk("held_leds", leds, 8'h00);
      repeat (19) step();
      chk("held_single_adv", {6'd0, mode}, 8'h00);
      mode_req = 1'b0;
      step();

      // Reset mid-SCAN with mode_req high overrides the advance.
      mode_req = 1'b1;
      step();
      mode_req = 1'b0;
      chk("scan2_mode", {6'd0, mode}, 8'h01);
      next_step();
      chk("scan2_step", leds, 8'h02);
      mode_req = 1'b1;
      rst      = 1'b1;
      step();
      chk("midrst_mode", {6'd0, mode}, 8'h00);
      chk("midrst_leds", leds, 8'h00);
      chk("midrst_tick", {7'd0, tick}, 8'h00);
      step();
      rst = 1'b0;
      repeat (6) step();
      chk("post_rst_no_adv", {6'd0, mode}, 8'h00);
      mode_req = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
